music_sequencer: RTL and testbench
==================================

// Module: music_sequencer
// PURPOSE
// - Plays a song stored in the music note ROM (sync ROM: 8-bit address in, 8-bit note out, 1-cycle read latency).
// - Steps the ROM address once per tempo tick and supports play, pause, stop, looping and a selectable tempo.
// - Feeds the tone generator with a muted-when-idle note code.
// - Sits between the user controls (debounced buttons/switches) and the ROM + tone generator.
// PARAMETERS
// - TICK_DIV   1_000_000  clk cycles per note step at normal tempo (>= 4)
// - SONG_LEN   201        number of ROM entries played; last address = SONG_LEN-1 (1..256)
// - ADDR_W     8          ROM address width
// - NOTE_W     8          note code width; code 0 = rest
// - CNT_W      27         tick counter width; must hold 2*TICK_DIV-1
// PORTS
// - clk         in   1       system clock
// - rst         in   1       asynchronous, active-high reset
// - play        in   1       1-cycle pulse: start from IDLE/DONE, or resume from PAUSE
// - pause       in   1       1-cycle pulse: freeze playback (PLAY only)
// - stop        in   1       1-cycle pulse: abort, return to address 0
// - loop_en     in   1       level: on reaching the last address, wrap to 0 instead of finishing
// - tempo_sel   in   2       00 normal (TICK_DIV), 01 fast (TICK_DIV/2), 10 slow (2*TICK_DIV), 11 = normal
// - rom_addr    out  ADDR_W  address to music ROM
// - rom_note    in   NOTE_W  ROM data, valid 1 cycle after rom_addr
// - note_out    out  NOTE_W  note code to tone generator; 0 when not playing
// - note_valid  out  1       note_out != 0 (non-rest, playing)
// - busy        out  1       state is PLAY or PAUSE
// - done        out  1       1-cycle pulse when a non-looping song finishes
// BEHAVIOUR
// - Reset values: state IDLE, rom_addr 0, tick_cnt 0, note_out 0, note_valid 0, busy 0, done 0, div_q = TICK_DIV.
// - States:
//   - IDLE -play-> PLAY (addr 0, tick_cnt 0).
//   - PLAY -pause-> PAUSE.
//   - PAUSE -play-> PLAY; tick_cnt and addr are retained.
//   - any -stop-> IDLE (addr 0, tick_cnt 0).
// - Control priority in the same cycle: stop > pause > play. Pulses that are illegal in the current state are ignored
//   (e.g. pause in IDLE, play in PLAY).
// - Tick: in PLAY only, tick_cnt counts 0..div_q-1. At div_q-1, tick_cnt goes to 0 and the address advances.
//   In any other state tick_cnt is frozen.
// - Tempo: div_q is re-latched from tempo_sel only when tick_cnt wraps, or when entering PLAY from IDLE.
//   A mid-note tempo change therefore never truncates or extends the current note.
// - Advance at addr < SONG_LEN-1: addr+1.
// - Advance at addr = SONG_LEN-1:
//   - loop_en=1: addr 0, stay in PLAY, no done.
//   - loop_en=0: addr 0, go to IDLE, done=1 for exactly one cycle.
// - Address arithmetic is unsigned, ADDR_W bits. It never exceeds SONG_LEN-1, so no natural wrap is relied on.
// - Output pipeline: note_out <= (state==PLAY) ? rom_note : 0, registered.
//   - Latency from a rom_addr change to note_out is 2 clk.
//   - Entering PAUSE, IDLE or reset mutes note_out on the next edge.
//   - After resuming from PAUSE, the current note reappears 2 clk later.
// - note_valid is registered alongside note_out: (state==PLAY) && (rom_note != 0).
// - busy is a registered function of the next state.
// - stop and done never assert together: if stop arrives on the final tick, stop wins and no done is issued.
// - Reset asserted mid-song returns immediately (asynchronously) to reset values.
// STRUCTURE
// - Package music_pkg:
//   - state enum {IDLE, PLAY, PAUSE}
//   - NOTE_REST = 0
//   - tempo_sel encodings TEMPO_NORM/FAST/SLOW
//   - shared with the ROM and tone generator
// - Sub-module tempo_tick_gen: holds tick_cnt and div_q.
//   - Inputs: clk, rst, run, restart, tempo_sel.
//   - Output: tick, a 1-cycle pulse.
// - The FSM, address counter and output registers stay in music_sequencer.
// TESTING (TICK_DIV=4, SONG_LEN=6, behavioural 1-cycle ROM with note[a] = a+10, except note[2] = 0)
// - Reset then play pulse:
//   - rom_addr steps 0,1,..,5 every 4 clk.
//   - note_out follows 2 clk after each address change; note_valid=0 while addr 2 is showing.
//   - After the last note: done pulses once, state goes IDLE, note_out=0.
// - loop_en=1, play: after addr 5 comes addr 0 with no done pulse; busy stays 1 across 3 full passes.
// - Pause mid-note (tick_cnt=2 at addr 3), hold 10 clk, then play:
//   - note_out=0 during the pause.
//   - After resume, addr 3 remains for exactly 2 more ticks-worth of clk (4-2=2), then goes to 4.
// - tempo_sel changed to 01 at tick_cnt=1: the current note still lasts 4 clk, subsequent notes last 2 clk.
//   - Then tempo_sel=10: notes last 8 clk from the next boundary.
// - stop+pause+play in the same cycle during PLAY: state IDLE, rom_addr 0, note_out 0 next cycle.
//   - Also: stop on the final tick gives no done pulse.
// - Reset asserted asynchronously mid-song (between clk edges): all outputs go to reset values before the next edge.
//   - A subsequent play restarts at addr 0.

Source files
------------

// File: rtl/music_pkg.sv
// -----------------------------------------------------------------------------
// music_pkg
// Shared definitions for the music sequencer, the note ROM and the tone
// generator.
//   seq_state_t   sequencer FSM states (IDLE, PLAY, PAUSE)
//   NOTE_REST     note code meaning "silence"
//   TEMPO_*       encodings of the 2-bit tempo_sel control
//   tempo_divisor clk cycles per note step for a given tempo_sel
// -----------------------------------------------------------------------------
package music_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2
  } seq_state_t;

  localparam int NOTE_REST = 0;

  localparam logic [1:0] TEMPO_NORM = 2'b00;
  localparam logic [1:0] TEMPO_FAST = 2'b01;
  localparam logic [1:0] TEMPO_SLOW = 2'b10;

  // 2'b11 is not a named tempo and plays at normal speed.
  function automatic logic [31:0] tempo_divisor(input logic [1:0]  sel,
                                                input logic [31:0] base);
    case (sel)
      TEMPO_FAST: return base >> 1;
      TEMPO_SLOW: return base << 1;
      default:    return base;
    endcase
  endfunction

endpackage

// File: rtl/tempo_tick_gen.sv
// -----------------------------------------------------------------------------
// tempo_tick_gen
// Note-step timer for the music sequencer. Counts clk cycles while running
// and emits a one-cycle tick at the last cycle of every note step.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   run        in   count this cycle (sequencer is playing and not pausing)
//   restart    in   clear the count and latch a fresh divisor
//   tempo_sel  in   requested tempo (TEMPO_NORM/FAST/SLOW)
//   tick       out  1-cycle pulse: current note step ends on this edge
// -----------------------------------------------------------------------------
module tempo_tick_gen
  import music_pkg::*;
#(
  parameter int TICK_DIV = 1_000_000,
  parameter int CNT_W    = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       restart,
  input  logic [1:0] tempo_sel,
  output logic       tick
);

  logic [CNT_W-1:0] tick_cnt;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] div_sel;
  logic             at_last;

  assign div_sel = CNT_W'(tempo_divisor(tempo_sel, 32'(TICK_DIV)));
  assign at_last = (tick_cnt == (div_q - CNT_W'(1)));
  assign tick    = run && at_last;

  // div_q only changes on a note boundary (wrap) or at a fresh start, so a
  // tempo change requested mid-note never alters the length of that note.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      div_q    <= CNT_W'(TICK_DIV);
    end else if (restart) begin
      tick_cnt <= '0;
      div_q    <= div_sel;
    end else if (tick) begin
      tick_cnt <= '0;
      div_q    <= div_sel;
    end else if (run) begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/music_sequencer.sv
// -----------------------------------------------------------------------------
// music_sequencer
// Walks the music note ROM one address per tempo tick and forwards the note
// codes to the tone generator. Supports play / pause / stop pulses, looping
// and three tempos.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   play       in   pulse: start from IDLE, resume from PAUSE
//   pause      in   pulse: freeze playback (only honoured in PLAY)
//   stop       in   pulse: abort from any state, back to address 0
//   loop_en    in   level: wrap to address 0 at song end instead of finishing
//   tempo_sel  in   00 normal, 01 fast, 10 slow, 11 normal
//   rom_addr   out  address to the sync note ROM (1-cycle read latency)
//   rom_note   in   ROM data for the previous cycle's rom_addr
//   note_out   out  note code to the tone generator, 0 unless playing
//   note_valid out  qualifier for note_out: high exactly when note_out is a
//                   non-rest note; there is no back-pressure, the tone
//                   generator simply samples note_out/note_valid every cycle
//   busy       out  state is PLAY or PAUSE
//   done       out  1-cycle pulse when a non-looping song finishes
//   dbg_state  out  current FSM state, for observation only
// Control priority within one cycle: stop > pause > play. Pulses that make no
// sense in the current state are dropped.
// -----------------------------------------------------------------------------
module music_sequencer
  import music_pkg::*;
#(
  parameter int TICK_DIV = 1_000_000,
  parameter int SONG_LEN = 201,
  parameter int ADDR_W   = 8,
  parameter int NOTE_W   = 8,
  parameter int CNT_W    = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              play,
  input  logic              pause,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [1:0]        tempo_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W-1:0] rom_note,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_valid,
  output logic              busy,
  output logic              done,
  output seq_state_t        dbg_state
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_d;
  logic              restart;
  logic              run;
  logic              tick;

  // The timer only advances in cycles that stay in PLAY: a pause pulse
  // freezes the count on the very cycle it arrives, so the remaining part of
  // the note is played in full after resuming.
  assign run = (state_q == PLAY) && !pause && !stop;

  tempo_tick_gen #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .restart   (restart),
    .tempo_sel (tempo_sel),
    .tick      (tick)
  );

  // Next-state, next-address and done decode.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    restart = 1'b0;

    if (stop) begin
      // Stop also clears the timer; the divisor it latches is irrelevant
      // because the next start from IDLE latches it again. Stop taking
      // precedence over the final tick is what keeps done low here.
      state_d = IDLE;
      addr_d  = '0;
      restart = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (play) begin
            state_d = PLAY;
            addr_d  = '0;
            restart = 1'b1;
          end
        end
        PLAY: begin
          if (pause) begin
            state_d = PAUSE;
          end else if (tick) begin
            if (addr_q == LAST_ADDR) begin
              addr_d = '0;
              if (!loop_en) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end
            end else begin
              addr_d = addr_q + ADDR_W'(1);
            end
          end
        end
        PAUSE: begin
          if (play) begin
            state_d = PLAY;
          end
        end
        default: begin
          state_d = IDLE;
          addr_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      done    <= done_d;
      busy    <= (state_d != IDLE);
    end
  end

  // rom_note already lags rom_addr by one cycle; registering it here gives
  // two cycles from an address change to note_out. Gating with the current
  // state mutes the output on the first edge after leaving PLAY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note_out   <= '0;
      note_valid <= 1'b0;
    end else if (state_q == PLAY) begin
      note_out   <= rom_note;
      note_valid <= (rom_note != NOTE_W'(NOTE_REST));
    end else begin
      note_out   <= '0;
      note_valid <= 1'b0;
    end
  end

  assign rom_addr  = addr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_music_sequencer.sv
module tb_music_sequencer;
  import music_pkg::*;

  localparam int TD = 4;
  localparam int SL = 6;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       play = 1'b0, pause = 1'b0, stop = 1'b0, loop_en = 1'b0;
  logic [1:0] tempo_sel = 2'b00;
  logic [7:0] rom_addr;
  logic [7:0] rom_note = 8'd0;
  logic [7:0] note_out;
  logic       note_valid, busy, done;
  seq_state_t dbg_state;

  always #5 clk = ~clk;

  music_sequencer #(
    .TICK_DIV (TD),
    .SONG_LEN (SL),
    .ADDR_W   (8),
    .NOTE_W   (8),
    .CNT_W    (27)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .play       (play),
    .pause      (pause),
    .stop       (stop),
    .loop_en    (loop_en),
    .tempo_sel  (tempo_sel),
    .rom_addr   (rom_addr),
    .rom_note   (rom_note),
    .note_out   (note_out),
    .note_valid (note_valid),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // Song contents: note[a] = a+10, except address 2 holds a rest.
  function automatic logic [7:0] note_of(input int a);
    if (a == 2) return 8'd0;
    return 8'(a + 10);
  endfunction

  // Behavioural synchronous ROM, one cycle of read latency.
  always @(posedge clk) rom_note <= note_of(int'(rom_addr));

  // ---------------- reference model ----------------
  // Plays the song by the rules: one address per note step, a step lasts
  // div cycles of PLAY, tempo re-chosen at each note boundary, output is the
  // ROM word of the previous cycle when the previous cycle was PLAY.
  seq_state_t m_state = IDLE;
  int         m_addr  = 0;
  int         m_cnt   = 0;
  int         m_div   = TD;
  logic [7:0] m_rom   = 8'd0;
  logic [7:0] m_nout  = 8'd0;
  logic       m_valid = 1'b0, m_busy = 1'b0, m_done = 1'b0;

  function automatic int div_for(input logic [1:0] s);
    if (s == 2'b01) return TD / 2;
    if (s == 2'b10) return TD * 2;
    return TD;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_state = IDLE; m_addr = 0; m_cnt = 0; m_div = TD;
      m_nout = 8'd0; m_valid = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    end else begin
      m_nout  = (m_state == PLAY) ? m_rom : 8'd0;
      m_valid = (m_state == PLAY) && (m_rom != 8'd0);
      m_rom   = note_of(m_addr);
      m_done  = 1'b0;
      if (stop) begin
        m_state = IDLE; m_addr = 0; m_cnt = 0;
      end else if (m_state == IDLE && play) begin
        m_state = PLAY; m_addr = 0; m_cnt = 0; m_div = div_for(tempo_sel);
      end else if (m_state == PAUSE && play) begin
        m_state = PLAY;
      end else if (m_state == PLAY && pause) begin
        m_state = PAUSE;
      end else if (m_state == PLAY) begin
        if (m_cnt == m_div - 1) begin
          m_cnt = 0;
          m_div = div_for(tempo_sel);
          if (m_addr == SL - 1) begin
            m_addr = 0;
            if (!loop_en) begin m_state = IDLE; m_done = 1'b1; end
          end else begin
            m_addr = m_addr + 1;
          end
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
      m_busy = (m_state != IDLE);
    end
  end

  wire [20:0] dut_vec = {rom_addr, note_out, note_valid, busy, done, dbg_state};
  wire [20:0] m_vec   = {m_addr[7:0], m_nout, m_valid, m_busy, m_done, m_state};

  int tests = 0;
  int fails = 0;

  // ---------------- driver tasks ----------------
  // Called at a negedge: present {stop,pause,play} for the next posedge,
  // then return at the following negedge with the pulses cleared.
  task automatic step(input logic [2:0] ctl);
    {stop, pause, play} = ctl;
    @(negedge clk);
    {stop, pause, play} = 3'b000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Steps until rom_addr changes; n = number of edges it took (bounded).
  task automatic wait_change(output int n);
    logic [7:0] a;
    a = rom_addr;
    n = 0;
    do begin
      step(3'b000);
      n++;
    end while (rom_addr == a && n < 64);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    tests++;
    if (rom_addr !== 8'd0) begin fails++; $display("FAIL reset_addr: got %0d want 0", rom_addr); end
    tests++;
    if ({note_out, note_valid} !== 9'd0) begin fails++; $display("FAIL reset_note: got %h/%b want 0/0", note_out, note_valid); end
    tests++;
    if ({busy, done} !== 2'b00) begin fails++; $display("FAIL reset_flags: busy=%b done=%b want 0 0", busy, done); end
    tests++;
    if (dbg_state !== IDLE) begin fails++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
    step(3'b010);  // pause in IDLE is ignored
    tests++;
    if (dbg_state !== IDLE || busy !== 1'b0) begin fails++; $display("FAIL idle_pause_ignored: state=%0d busy=%b want IDLE 0", dbg_state, busy); end
  endtask

  task automatic test_play_song();
    logic [7:0] exp_q[$];
    logic [7:0] prev, want;
    int hold, done_cnt, rest_cnt;
    do_reset();
    loop_en = 1'b0; tempo_sel = TEMPO_NORM;
    exp_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0};
    step(3'b001);
    tests++;
    if (dbg_state !== PLAY || rom_addr !== 8'd0 || busy !== 1'b1) begin
      fails++; $display("FAIL play_start: state=%0d addr=%0d busy=%b want PLAY 0 1", dbg_state, rom_addr, busy);
    end
    prev = rom_addr; hold = 1; done_cnt = 0; rest_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step(3'b000);
      tests++;
      if (dut_vec !== m_vec) begin fails++; $display("FAIL song_cycle %0d: dut=%h model=%h", i, dut_vec, m_vec); end
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1 && note_valid === 1'b0) rest_cnt++;
      if (rom_addr !== prev) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hff;
        tests++;
        if (rom_addr !== want || hold != TD) begin
          fails++; $display("FAIL song_step: addr=%0d after %0d clk, want addr %0d after %0d clk", rom_addr, hold, want, TD);
        end
        prev = rom_addr; hold = 1;
      end else begin
        hold++;
      end
    end
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL song_steps_left: got %0d want 0", exp_q.size()); end
    tests++;
    if (done_cnt != 1) begin fails++; $display("FAIL song_done_count: got %0d want 1", done_cnt); end
    tests++;
    if (rest_cnt != TD) begin fails++; $display("FAIL song_rest_cycles: got %0d want %0d", rest_cnt, TD); end
    tests++;
    if (busy !== 1'b0 || note_out !== 8'd0 || dbg_state !== IDLE) begin
      fails++; $display("FAIL song_end: busy=%b note=%0d state=%0d want 0 0 IDLE", busy, note_out, dbg_state);
    end
  endtask

  task automatic test_loop();
    int bad;
    do_reset();
    loop_en = 1'b1;
    step(3'b001);
    bad = 0;
    for (int i = 0; i < 3 * SL * TD + 4; i++) begin
      step(3'b000);
      tests++;
      if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL loop_flags %0d: busy=%b done=%b want 1 0", i, busy, done); end
      tests++;
      if (dut_vec !== m_vec) begin fails++; $display("FAIL loop_cycle %0d: dut=%h model=%h", i, dut_vec, m_vec); end
    end
    step(3'b100);
    loop_en = 1'b0;
  endtask

  task automatic test_pause();
    int k, n;
    do_reset();
    step(3'b001);
    k = 0;
    while (!(m_addr == 3 && m_cnt == 2) && k < 100) begin step(3'b000); k++; end
    tests++;
    if (k >= 100) begin fails++; $display("FAIL pause_reach: no addr 3 / count 2 within %0d clk", k); end
    step(3'b010);
    for (int i = 0; i < 10; i++) begin
      step(3'b000);
      tests++;
      if (note_out !== 8'd0 || dbg_state !== PAUSE || rom_addr !== 8'd3) begin
        fails++; $display("FAIL pause_hold %0d: note=%0d state=%0d addr=%0d want 0 PAUSE 3", i, note_out, dbg_state, rom_addr);
      end
    end
    step(3'b001);
    step(3'b000);
    tests++;
    if (note_out !== note_of(3)) begin fails++; $display("FAIL resume_note: got %0d want %0d", note_out, note_of(3)); end
    wait_change(n);
    // one of the two remaining note cycles was already spent above
    tests++;
    if (n != 1 || rom_addr !== 8'd4) begin fails++; $display("FAIL resume_remaining: addr=%0d after %0d clk, want 4 after 1", rom_addr, n); end
    step(3'b100);
  endtask

  task automatic test_tempo();
    int n;
    int want[5] = '{2, 2, 2, 8, 8};
    do_reset();
    loop_en = 1'b1; tempo_sel = TEMPO_NORM;
    step(3'b001);
    wait_change(n);
    step(3'b000);
    tempo_sel = TEMPO_FAST;  // tick_cnt is 1 here
    wait_change(n);
    tests++;
    if (n + 1 != TD) begin fails++; $display("FAIL tempo_current_note: lasted %0d clk want %0d", n + 1, TD); end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) tempo_sel = TEMPO_SLOW;
      wait_change(n);
      tests++;
      if (n != want[i]) begin fails++; $display("FAIL tempo_note %0d: lasted %0d clk want %0d", i, n, want[i]); end
    end
    tempo_sel = TEMPO_NORM;
    step(3'b100);
    loop_en = 1'b0;
  endtask

  task automatic test_stop();
    int k;
    do_reset();
    loop_en = 1'b0;
    step(3'b001);
    repeat (5) step(3'b000);
    step(3'b111);
    tests++;
    if (rom_addr !== 8'd0 || busy !== 1'b0 || dbg_state !== IDLE || done !== 1'b0) begin
      fails++; $display("FAIL stop_all: addr=%0d busy=%b state=%0d done=%b want 0 0 IDLE 0", rom_addr, busy, dbg_state, done);
    end
    step(3'b000);
    tests++;
    if (note_out !== 8'd0 || note_valid !== 1'b0) begin fails++; $display("FAIL stop_mute: note=%0d valid=%b want 0 0", note_out, note_valid); end
    step(3'b001);
    k = 0;
    while (!(m_addr == SL - 1 && m_cnt == m_div - 1) && k < 200) begin step(3'b000); k++; end
    tests++;
    if (k >= 200) begin fails++; $display("FAIL stop_reach_final: not reached within %0d clk", k); end
    step(3'b100);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (done !== 1'b0 || busy !== 1'b0 || rom_addr !== 8'd0) begin
        fails++; $display("FAIL stop_final_tick %0d: done=%b busy=%b addr=%0d want 0 0 0", i, done, busy, rom_addr);
      end
      step(3'b000);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(3'b001);
    repeat (9) step(3'b000);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if (dut_vec !== 21'd0) begin fails++; $display("FAIL async_reset: outputs=%h want 0", dut_vec); end
    @(negedge clk);
    rst = 1'b0;
    step(3'b001);
    tests++;
    if (rom_addr !== 8'd0 || busy !== 1'b1 || dbg_state !== PLAY) begin
      fails++; $display("FAIL restart_after_reset: addr=%0d busy=%b state=%0d want 0 1 PLAY", rom_addr, busy, dbg_state);
    end
    for (int i = 0; i < 10; i++) begin
      step(3'b000);
      tests++;
      if (dut_vec !== m_vec) begin fails++; $display("FAIL restart_cycle %0d: dut=%h model=%h", i, dut_vec, m_vec); end
    end
    step(3'b100);
  endtask

  task automatic test_random();
    int r;
    logic [2:0] ctl;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3)       ctl = 3'b100;
      else if (r < 8)  ctl = 3'b010;
      else if (r < 18) ctl = 3'b001;
      else if (r < 20) ctl = 3'b111;
      else if (r < 22) ctl = 3'b011;
      else             ctl = 3'b000;
      if ($urandom_range(0, 29) == 0) tempo_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) loop_en = 1'($urandom_range(0, 1));
      step(ctl);
      tests++;
      if (dut_vec !== m_vec) begin fails++; $display("FAIL random_cycle %0d: dut=%h model=%h", i, dut_vec, m_vec); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_play_song();
    test_loop();
    test_pause();
    test_tempo();
    test_stop();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
